// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: steps each instruction through fetch,
// decode, execute, memory and writeback while steering the shared datapath.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_br_eq,
  input  logic        i_br_lt,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_adr_src,
  output logic        o_mem_read_en,
  output logic        o_mem_write_en,
  output logic        o_reg_write_en,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [2:0]  o_imm_src,
  output logic [1:0]  o_result_src,
  output logic [3:0]  o_alu_control,
  output logic        o_br_un,
  output logic        o_illegal,
  output logic [3:0]  o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef struct packed {
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
  } moore_t;

  state_t     r_state;
  moore_t     r_moore;
  logic       r_illegal;

  state_t     w_next;
  logic       w_ready;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7_5;
  logic       w_take;
  logic       w_br_bad;
  logic [3:0] w_alu_op;
  logic       w_unused;

  assign w_opcode   = i_instr[6:0];
  assign w_funct3   = i_instr[14:12];
  assign w_funct7_5 = i_instr[30];
  assign w_unused   = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};
  assign w_ready    = MEM_WAIT_EN ? i_mem_ready : 1'b1;

  // Datapath steering that depends only on the state; registered against the next state.
  function automatic moore_t mooreDecode(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:    begin m.mem_read = 1'b1; m.src_b = 2'b10; m.result_src = 2'b10; end
      S_DECODE:   begin m.src_a = 2'b01; m.src_b = 2'b01; end
      S_MEMADR:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
      S_MEMREAD:  begin m.adr_src = 1'b1; m.mem_read = 1'b1; end
      S_MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; end
      S_MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
      S_EXEC_R:   begin m.src_a = 2'b10; m.src_b = 2'b00; end
      S_EXEC_I:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
      S_ALUWB:    begin m.reg_write = 1'b1; end
      S_BRANCH:   begin m.src_a = 2'b10; m.src_b = 2'b00; end
      S_JAL:      begin m.src_a = 2'b01; m.src_b = 2'b10; m.pc_write = 1'b1; end
      S_JALR:     begin m.src_a = 2'b10; m.src_b = 2'b01; m.result_src = 2'b10; m.pc_write = 1'b1; end
      S_LUI:      begin m.src_a = 2'b11; m.src_b = 2'b01; end
      S_AUIPC:    begin m.src_a = 2'b01; m.src_b = 2'b01; end
      default:    ;
    endcase
    return m;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = S_ALUWB;
      S_EXEC_I:   w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_JAL;
      S_LUI:      w_next = S_ALUWB;
      S_AUIPC:    w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_ILLEGAL;
    endcase
  end

  // funct3 010/011 are not branches; they never take and flag the core illegal.
  always_comb begin
    w_take   = 1'b0;
    w_br_bad = 1'b0;
    case (w_funct3)
      3'b000:         w_take = i_br_eq;
      3'b001:         w_take = !i_br_eq;
      3'b100, 3'b110: w_take = i_br_lt;
      3'b101, 3'b111: w_take = !i_br_lt;
      default:        w_br_bad = 1'b1;
    endcase
  end

  // Bit 30 only means subtract for R-type; for immediates it is part of the constant except on srai.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = (w_opcode == OP_R && w_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = w_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    o_alu_control = ALU_ADD;
    o_imm_src     = IMM_I;
    o_br_un       = 1'b0;
    case (r_state)
      S_DECODE:           o_imm_src = IMM_B;
      S_MEMADR:           o_imm_src = w_opcode[5] ? IMM_S : IMM_I;
      S_EXEC_R, S_EXEC_I: o_alu_control = w_alu_op;
      S_BRANCH: begin
        o_alu_control = ALU_SUB;
        o_br_un       = w_funct3[2] & w_funct3[1];
      end
      S_LUI, S_AUIPC:     o_imm_src = IMM_U;
      default:            ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= state_t'(RESET_STATE);
      r_moore   <= mooreDecode(state_t'(RESET_STATE));
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_moore <= mooreDecode(w_next);
      if (w_next == S_ILLEGAL || (r_state == S_BRANCH && w_br_bad)) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign o_pc_write     = r_moore.pc_write
                        | (r_state == S_FETCH && w_ready)
                        | (r_state == S_BRANCH && w_take);
  assign o_ir_write     = (r_state == S_FETCH) && w_ready;
  assign o_adr_src      = r_moore.adr_src;
  assign o_mem_read_en  = r_moore.mem_read;
  assign o_mem_write_en = r_moore.mem_write;
  assign o_reg_write_en = r_moore.reg_write;
  assign o_alu_src_a    = r_moore.src_a;
  assign o_alu_src_b    = r_moore.src_b;
  assign o_result_src   = r_moore.result_src;
  assign o_illegal      = r_illegal;
  assign o_state        = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction walks push
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11;
  localparam logic [3:0] S_LUI = 4'd12, S_AUIPC = 4'd13, S_ILLEGAL = 4'd14;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010, ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_OR = 4'b1000, ALU_AND = 4'b1001;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [1:0] res;
    logic [3:0] alu;
    logic       un;
    logic       ill;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        brEq, brLt, memReady;
  logic        pcWrite, irWrite, adrSrc, memReadEn, memWriteEn, regWriteEn;
  logic [1:0]  aluSrcA, aluSrcB, resultSrc;
  logic [2:0]  immSrc;
  logic [3:0]  aluControl, state;
  logic        brUn, illegal;

  int   testsRun = 0;
  int   testsFailed = 0;
  obs_t expQ[$];
  string nameQ[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_br_eq(brEq), .i_br_lt(brLt),
    .i_mem_ready(memReady), .o_pc_write(pcWrite), .o_ir_write(irWrite),
    .o_adr_src(adrSrc), .o_mem_read_en(memReadEn), .o_mem_write_en(memWriteEn),
    .o_reg_write_en(regWriteEn), .o_alu_src_a(aluSrcA), .o_alu_src_b(aluSrcB),
    .o_imm_src(immSrc), .o_result_src(resultSrc), .o_alu_control(aluControl),
    .o_br_un(brUn), .o_illegal(illegal), .o_state(state)
  );

  // Expected record: per-state datapath steering, plus the instruction/input dependent fields.
  function automatic obs_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic [2:0] imm, input logic [3:0] alu,
                              input logic un, input logic ill);
    obs_t e;
    e = '0;
    e.st = st; e.pcw = pcw; e.irw = irw; e.imm = imm; e.alu = alu; e.un = un; e.ill = ill;
    case (st)
      S_FETCH:    begin e.mr = 1'b1; e.b = 2'b10; e.res = 2'b10; end
      S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
      S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
      S_MEMREAD:  begin e.adr = 1'b1; e.mr = 1'b1; end
      S_MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXEC_R:   begin e.a = 2'b10; e.b = 2'b00; end
      S_EXEC_I:   begin e.a = 2'b10; e.b = 2'b01; end
      S_ALUWB:    begin e.rw = 1'b1; e.res = 2'b00; end
      S_BRANCH:   begin e.a = 2'b10; e.b = 2'b00; e.res = 2'b00; end
      S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.res = 2'b00; end
      S_JALR:     begin e.a = 2'b10; e.b = 2'b01; e.res = 2'b10; end
      S_LUI:      begin e.a = 2'b11; e.b = 2'b01; end
      S_AUIPC:    begin e.a = 2'b01; e.b = 2'b01; end
      default:    ;
    endcase
    return e;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d pcw=%b irw=%b adr=%b mr=%b mw=%b rw=%b a=%b b=%b imm=%b res=%b alu=%b un=%b ill=%b",
                     o.st, o.pcw, o.irw, o.adr, o.mr, o.mw, o.rw, o.a, o.b, o.imm, o.res, o.alu, o.un, o.ill);
  endfunction

  task automatic checkOutput(input obs_t e, input string name);
    obs_t o;
    o = '{st: state, pcw: pcWrite, irw: irWrite, adr: adrSrc, mr: memReadEn, mw: memWriteEn,
          rw: regWriteEn, a: aluSrcA, b: aluSrcB, imm: immSrc, res: resultSrc,
          alu: aluControl, un: brUn, ill: illegal};
    testsRun++;
    if (o !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %s | expected %s", name, fmt(o), fmt(e));
    end
  endtask

  // One clock cycle: drive inputs just after the edge and queue what the DUT should show this cycle.
  task automatic applyStimulus(input logic rstIn, input logic [31:0] instrIn, input logic rdyIn,
                               input logic eqIn, input logic ltIn, input obs_t e, input string name);
    @(posedge clk);
    #1;
    rst = rstIn; instr = instrIn; memReady = rdyIn; brEq = eqIn; brLt = ltIn;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic runSimple(input logic [31:0] ins, input logic [3:0] execSt, input logic [2:0] execImm,
                           input logic [3:0] execAlu, input logic execPcw, input string name);
    applyStimulus(1'b0, ins, 1'b1, 1'b0, 1'b0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), {name, "/fetch"});
    applyStimulus(1'b0, ins, 1'b1, 1'b0, 1'b0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), {name, "/decode"});
    applyStimulus(1'b0, ins, 1'b1, 1'b0, 1'b0, mk(execSt, execPcw, 0, execImm, execAlu, 0, 0), {name, "/exec"});
    applyStimulus(1'b0, ins, 1'b1, 1'b0, 1'b0, mk(S_ALUWB, 0, 0, IMM_I, ALU_ADD, 0, 0), {name, "/wb"});
  endtask

  task automatic runBranch(input logic [31:0] ins, input logic eq, input logic lt,
                           input logic take, input logic un, input string name);
    applyStimulus(1'b0, ins, 1'b1, eq, lt, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), {name, "/fetch"});
    applyStimulus(1'b0, ins, 1'b1, eq, lt, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), {name, "/decode"});
    applyStimulus(1'b0, ins, 1'b1, eq, lt, mk(S_BRANCH, take, 0, IMM_I, ALU_SUB, un, 0), {name, "/branch"});
  endtask

  initial begin : monitor
    obs_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(e, n);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst = 1'b1; instr = 32'h0; memReady = 1'b0; brEq = 1'b0; brLt = 1'b0;

    applyStimulus(1'b1, 32'h0, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "reset0");
    applyStimulus(1'b1, 32'h0, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "reset1");

    runSimple(32'h002081B3, S_EXEC_R, IMM_I, ALU_ADD, 1'b0, "add");

    applyStimulus(1'b0, 32'h0000A183, 1'b1, 0, 0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "lw/fetch");
    applyStimulus(1'b0, 32'h0000A183, 1'b1, 0, 0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "lw/decode");
    applyStimulus(1'b0, 32'h0000A183, 1'b1, 0, 0, mk(S_MEMADR, 0, 0, IMM_I, ALU_ADD, 0, 0), "lw/memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h0000A183, 1'b0, 0, 0, mk(S_MEMREAD, 0, 0, IMM_I, ALU_ADD, 0, 0), "lw/wait");
    applyStimulus(1'b0, 32'h0000A183, 1'b1, 0, 0, mk(S_MEMREAD, 0, 0, IMM_I, ALU_ADD, 0, 0), "lw/ready");
    applyStimulus(1'b0, 32'h0000A183, 1'b1, 0, 0, mk(S_MEMWB, 0, 0, IMM_I, ALU_ADD, 0, 0), "lw/wb");

    runBranch(32'h00208463, 1'b1, 1'b0, 1'b1, 1'b0, "beq_taken");
    runBranch(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0, "beq_not");
    runBranch(32'h00209463, 1'b0, 1'b0, 1'b1, 1'b0, "bne_taken");
    runBranch(32'h0020C463, 1'b0, 1'b0, 1'b0, 1'b0, "blt_not");
    runBranch(32'h0020E463, 1'b0, 1'b1, 1'b1, 1'b1, "bltu_taken");
    runBranch(32'h0020D463, 1'b0, 1'b1, 1'b0, 1'b0, "bge_not");
    runBranch(32'h0020F463, 1'b0, 1'b0, 1'b1, 1'b1, "bgeu_taken");

    runSimple(32'h402081B3, S_EXEC_R, IMM_I, ALU_SUB,  1'b0, "sub");
    runSimple(32'h002091B3, S_EXEC_R, IMM_I, ALU_SLL,  1'b0, "sll");
    runSimple(32'h0020A1B3, S_EXEC_R, IMM_I, ALU_SLT,  1'b0, "slt");
    runSimple(32'h0020B1B3, S_EXEC_R, IMM_I, ALU_SLTU, 1'b0, "sltu");
    runSimple(32'h0020C1B3, S_EXEC_R, IMM_I, ALU_XOR,  1'b0, "xor");
    runSimple(32'h0020D1B3, S_EXEC_R, IMM_I, ALU_SRL,  1'b0, "srl");
    runSimple(32'h4020D1B3, S_EXEC_R, IMM_I, ALU_SRA,  1'b0, "sra");
    runSimple(32'h0020E1B3, S_EXEC_R, IMM_I, ALU_OR,   1'b0, "or");
    runSimple(32'h0020F1B3, S_EXEC_R, IMM_I, ALU_AND,  1'b0, "and");
    runSimple(32'h40008193, S_EXEC_I, IMM_I, ALU_ADD,  1'b0, "addi_bit30");
    runSimple(32'h4010D193, S_EXEC_I, IMM_I, ALU_SRA,  1'b0, "srai");
    runSimple(32'h0010D193, S_EXEC_I, IMM_I, ALU_SRL,  1'b0, "srli");
    runSimple(32'h0010B193, S_EXEC_I, IMM_I, ALU_SLTU, 1'b0, "sltiu");
    runSimple(32'h000001B7, S_LUI,    IMM_U, ALU_ADD,  1'b0, "lui");
    runSimple(32'h00000197, S_AUIPC,  IMM_U, ALU_ADD,  1'b0, "auipc");
    runSimple(32'h0000006F, S_JAL,    IMM_I, ALU_ADD,  1'b1, "jal");

    applyStimulus(1'b0, 32'h00008067, 1'b1, 0, 0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "jalr/fetch");
    applyStimulus(1'b0, 32'h00008067, 1'b1, 0, 0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "jalr/decode");
    applyStimulus(1'b0, 32'h00008067, 1'b1, 0, 0, mk(S_JALR, 1, 0, IMM_I, ALU_ADD, 0, 0), "jalr/jalr");
    applyStimulus(1'b0, 32'h00008067, 1'b1, 0, 0, mk(S_JAL, 1, 0, IMM_I, ALU_ADD, 0, 0), "jalr/jal");
    applyStimulus(1'b0, 32'h00008067, 1'b1, 0, 0, mk(S_ALUWB, 0, 0, IMM_I, ALU_ADD, 0, 0), "jalr/wb");

    applyStimulus(1'b0, 32'h0000007F, 1'b1, 0, 0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "illop/fetch");
    applyStimulus(1'b0, 32'h0000007F, 1'b1, 0, 0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "illop/decode");
    applyStimulus(1'b0, 32'h0000007F, 1'b1, 0, 0, mk(S_ILLEGAL, 0, 0, IMM_I, ALU_ADD, 0, 1), "illop/enter");
    applyStimulus(1'b0, 32'h002081B3, 1'b1, 0, 0, mk(S_ILLEGAL, 0, 0, IMM_I, ALU_ADD, 0, 1), "illop/sticky");
    applyStimulus(1'b1, 32'h002081B3, 1'b0, 0, 0, mk(S_ILLEGAL, 0, 0, IMM_I, ALU_ADD, 0, 1), "illop/rstcycle");
    applyStimulus(1'b0, 32'h002081B3, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "illop/cleared");

    applyStimulus(1'b0, 32'h0020A463, 1'b1, 1, 1, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "badbr/fetch");
    applyStimulus(1'b0, 32'h0020A463, 1'b1, 1, 1, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "badbr/decode");
    applyStimulus(1'b0, 32'h0020A463, 1'b1, 1, 1, mk(S_BRANCH, 0, 0, IMM_I, ALU_SUB, 0, 0), "badbr/branch");
    applyStimulus(1'b0, 32'h0020A463, 1'b0, 1, 1, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 1), "badbr/flag");
    applyStimulus(1'b1, 32'h0020A463, 1'b0, 1, 1, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 1), "badbr/rstcycle");
    applyStimulus(1'b0, 32'h0020A463, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "badbr/cleared");

    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "sw/fetch");
    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "sw/decode");
    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_MEMADR, 0, 0, IMM_S, ALU_ADD, 0, 0), "sw/memadr");
    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_MEMWRITE, 0, 0, IMM_I, ALU_ADD, 0, 0), "sw/write");

    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_FETCH, 1, 1, IMM_I, ALU_ADD, 0, 0), "swrst/fetch");
    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_DECODE, 0, 0, IMM_B, ALU_ADD, 0, 0), "swrst/decode");
    applyStimulus(1'b0, 32'h0020A023, 1'b1, 0, 0, mk(S_MEMADR, 0, 0, IMM_S, ALU_ADD, 0, 0), "swrst/memadr");
    applyStimulus(1'b0, 32'h0020A023, 1'b0, 0, 0, mk(S_MEMWRITE, 0, 0, IMM_I, ALU_ADD, 0, 0), "swrst/wait");
    applyStimulus(1'b1, 32'h0020A023, 1'b0, 0, 0, mk(S_MEMWRITE, 0, 0, IMM_I, ALU_ADD, 0, 0), "swrst/rstcycle");
    applyStimulus(1'b0, 32'h0020A023, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "swrst/fetch_after");
    applyStimulus(1'b0, 32'h0020A023, 1'b0, 0, 0, mk(S_FETCH, 0, 0, IMM_I, ALU_ADD, 0, 0), "swrst/hold");

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
